// File: rtl/interrupt_ctrl_unit.sv
// Multi-source interrupt controller and entry sequencer.
// Latches rising edges on the request lines, picks the lowest pending
// unmasked line, stalls and drains the pipe, pushes the return PC and flags,
// reads the handler address from the vector table and redirects fetch.
// Every output is registered and computed from the next-state values.
module interrupt_ctrl_unit #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned FLAG_WIDTH   = 3,
    parameter int unsigned VECTOR_BASE  = 0,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [NUM_IRQ-1:0]    irq_mask_i,
    input  logic                  rti_i,
    input  logic [PC_WIDTH-1:0]   pc_in_i,
    input  logic [FLAG_WIDTH-1:0] flags_in_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  int_flag_o,
    output logic                  stall_fetch_o,
    output logic                  branch_o,
    output logic                  dmr_o,
    output logic                  dmw_o,
    output logic                  stack_operation_o,
    output logic                  push_pop_o,
    output logic                  write_sp_o,
    output logic [3:0]            alu_function_o,
    output logic [DATA_WIDTH-1:0] int_data_o,
    output logic [ADDR_WIDTH-1:0] int_addr_o,
    output logic [PC_WIDTH-1:0]   new_pc_o,
    output logic [NUM_IRQ-1:0]    irq_ack_o,
    output logic                  ie_o
);

    localparam int unsigned WORDS   = PC_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_MAX = (DRAIN_CYCLES > WORDS) ? DRAIN_CYCLES : WORDS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [3:0] AluPassB = 4'b0100;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPushPc,
        StPushFlags,
        StLoadVec,
        StCapture,
        StJump
    } state_e;

    // Sequencer state
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [PC_WIDTH-1:0]   saved_pc_q, saved_pc_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic [PC_WIDTH-1:0]   vec_q, vec_d;
    logic [NUM_IRQ-1:0]    pending_q, pending_d;
    logic [NUM_IRQ-1:0]    irq_q, irq_d;
    logic                  ie_q, ie_d;

    // Registered outputs
    logic                  int_flag_q, int_flag_d;
    logic                  stall_q, stall_d;
    logic                  branch_q, branch_d;
    logic                  dmr_q, dmr_d;
    logic                  dmw_q, dmw_d;
    logic                  stack_op_q, stack_op_d;
    logic                  push_pop_q, push_pop_d;
    logic                  write_sp_q, write_sp_d;
    logic [3:0]            alu_fn_q, alu_fn_d;
    logic [DATA_WIDTH-1:0] int_data_q, int_data_d;
    logic [ADDR_WIDTH-1:0] int_addr_q, int_addr_d;
    logic [PC_WIDTH-1:0]   new_pc_q, new_pc_d;
    logic [NUM_IRQ-1:0]    irq_ack_q, irq_ack_d;

    logic [NUM_IRQ-1:0]    eligible;
    logic [ID_W-1:0]       sel_id;
    logic                  push_d;

    // Fixed-priority pick: lowest eligible index wins
    always_comb begin
        eligible = pending_q & ~irq_mask_i;
        sel_id   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // Next-state logic for the sequencer, pending latch and interrupt enable
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        saved_pc_d = saved_pc_q;
        flags_d    = flags_q;
        vec_d      = vec_q;
        irq_d      = irq_i;
        // A new edge beats the acknowledge clear in the same cycle
        pending_d  = (pending_q & ~irq_ack_q) | (irq_i & ~irq_q);
        ie_d       = rti_i ? 1'b1 : ie_q;

        unique case (state_q)
            StIdle: begin
                if (ie_q && (eligible != '0)) begin
                    id_d       = sel_id;
                    saved_pc_d = pc_in_i;
                    ie_d       = 1'b0;  // entry clear wins over a coincident rti
                    cnt_d      = '0;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    flags_d = flags_in_i;
                    cnt_d   = '0;
                    state_d = StPushPc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPushPc: begin
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = StPushFlags;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPushFlags: begin
                cnt_d   = '0;
                state_d = StLoadVec;
            end
            StLoadVec: begin
                // Read data trails the request by one cycle
                if (cnt_q != '0) begin
                    vec_d = (vec_q << DATA_WIDTH) | PC_WIDTH'(mem_rdata_i);
                end
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCapture: begin
                vec_d   = (vec_q << DATA_WIDTH) | PC_WIDTH'(mem_rdata_i);
                state_d = StJump;
            end
            StJump: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from next-state values so outputs line up with the state
    always_comb begin
        push_d     = (state_d == StPushPc) || (state_d == StPushFlags);
        int_flag_d = (state_d != StIdle);
        stall_d    = (state_d != StIdle);
        branch_d   = (state_d == StJump);
        dmr_d      = (state_d == StLoadVec);
        dmw_d      = push_d;
        stack_op_d = push_d;
        push_pop_d = push_d;
        write_sp_d = push_d;
        alu_fn_d   = push_d ? AluPassB : 4'b0000;
        int_data_d = '0;
        int_addr_d = '0;
        new_pc_d   = '0;
        irq_ack_d  = '0;

        if (state_d == StPushPc) begin
            // Most-significant word first
            int_data_d = DATA_WIDTH'(saved_pc_d >> (DATA_WIDTH * (WORDS - 1 - 32'(cnt_d))));
        end
        if (state_d == StPushFlags) begin
            int_data_d = DATA_WIDTH'(flags_d);
        end
        if (state_d == StLoadVec) begin
            int_addr_d = ADDR_WIDTH'(VECTOR_BASE + 32'(id_d) * WORDS + 32'(cnt_d));
        end
        if (state_d == StJump) begin
            new_pc_d  = vec_d;
            irq_ack_d = NUM_IRQ'(1) << id_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            id_q       <= '0;
            saved_pc_q <= '0;
            flags_q    <= '0;
            vec_q      <= '0;
            pending_q  <= '0;
            irq_q      <= '0;
            ie_q       <= 1'b1;
            int_flag_q <= 1'b0;
            stall_q    <= 1'b0;
            branch_q   <= 1'b0;
            dmr_q      <= 1'b0;
            dmw_q      <= 1'b0;
            stack_op_q <= 1'b0;
            push_pop_q <= 1'b0;
            write_sp_q <= 1'b0;
            alu_fn_q   <= 4'b0000;
            int_data_q <= '0;
            int_addr_q <= '0;
            new_pc_q   <= '0;
            irq_ack_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            saved_pc_q <= saved_pc_d;
            flags_q    <= flags_d;
            vec_q      <= vec_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            ie_q       <= ie_d;
            int_flag_q <= int_flag_d;
            stall_q    <= stall_d;
            branch_q   <= branch_d;
            dmr_q      <= dmr_d;
            dmw_q      <= dmw_d;
            stack_op_q <= stack_op_d;
            push_pop_q <= push_pop_d;
            write_sp_q <= write_sp_d;
            alu_fn_q   <= alu_fn_d;
            int_data_q <= int_data_d;
            int_addr_q <= int_addr_d;
            new_pc_q   <= new_pc_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    assign int_flag_o        = int_flag_q;
    assign stall_fetch_o     = stall_q;
    assign branch_o          = branch_q;
    assign dmr_o             = dmr_q;
    assign dmw_o             = dmw_q;
    assign stack_operation_o = stack_op_q;
    assign push_pop_o        = push_pop_q;
    assign write_sp_o        = write_sp_q;
    assign alu_function_o    = alu_fn_q;
    assign int_data_o        = int_data_q;
    assign int_addr_o        = int_addr_q;
    assign new_pc_o          = new_pc_q;
    assign irq_ack_o         = irq_ack_q;
    assign ie_o              = ie_q;

endmodule

// File: tb/tb_interrupt_ctrl_unit.sv
// Bench for interrupt_ctrl_unit: directed scenarios followed by random traffic,
// all cycles checked against a phase-indexed reference model of the sequence.
module tb_interrupt_ctrl_unit;

    localparam int NI   = 4;
    localparam int PCW  = 32;
    localparam int DW   = 16;
    localparam int AW   = 20;
    localparam int FW   = 3;
    localparam int VB   = 0;
    localparam int DC   = 3;
    localparam int W    = PCW / DW;
    localparam int LAST = DC + 2 * W + 2;  // phase index of the jump cycle

    logic          clk;
    logic          rst_i;
    logic [NI-1:0] irq_i;
    logic [NI-1:0] irq_mask_i;
    logic          rti_i;
    logic [PCW-1:0] pc_in_i;
    logic [FW-1:0] flags_in_i;
    logic [DW-1:0] mem_rdata_i;
    logic          int_flag_o, stall_fetch_o, branch_o, dmr_o, dmw_o;
    logic          stack_operation_o, push_pop_o, write_sp_o, ie_o;
    logic [3:0]    alu_function_o;
    logic [DW-1:0] int_data_o;
    logic [AW-1:0] int_addr_o;
    logic [PCW-1:0] new_pc_o;
    logic [NI-1:0] irq_ack_o;

    interrupt_ctrl_unit #(
        .NUM_IRQ(NI), .PC_WIDTH(PCW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .FLAG_WIDTH(FW), .VECTOR_BASE(VB), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i), .irq_mask_i(irq_mask_i),
        .rti_i(rti_i), .pc_in_i(pc_in_i), .flags_in_i(flags_in_i),
        .mem_rdata_i(mem_rdata_i), .int_flag_o(int_flag_o),
        .stall_fetch_o(stall_fetch_o), .branch_o(branch_o), .dmr_o(dmr_o),
        .dmw_o(dmw_o), .stack_operation_o(stack_operation_o),
        .push_pop_o(push_pop_o), .write_sp_o(write_sp_o),
        .alu_function_o(alu_function_o), .int_data_o(int_data_o),
        .int_addr_o(int_addr_o), .new_pc_o(new_pc_o), .irq_ack_o(irq_ack_o),
        .ie_o(ie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: m_t is the cycle index inside a service sequence, -1 idle
    logic [NI-1:0]  m_pend, m_prev;
    logic           m_ie;
    int             m_t;
    int             m_id;
    logic [PCW-1:0] m_pc, m_vec;
    logic [FW-1:0]  m_flags;
    logic [DW-1:0]  vec_mem [NI*W];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [NI-1:0] ack, elig;
        logic          ie_n;
        int            t_n, sel;
        if (rst_i) begin
            m_pend = '0; m_prev = '0; m_ie = 1'b1; m_t = -1;
            return;
        end
        ack  = (m_t == LAST) ? NI'(1 << m_id) : '0;
        elig = m_pend & ~irq_mask_i;
        if (m_t == DC - 1) m_flags = flags_in_i;
        if (m_t >= DC + W + 2 && m_t <= DC + 2 * W + 1) m_vec = (m_vec << DW) | PCW'(mem_rdata_i);
        ie_n = rti_i ? 1'b1 : m_ie;
        t_n  = -1;
        if (m_t < 0) begin
            if (m_ie && elig != '0) begin
                sel = -1;
                for (int i = 0; i < NI; i++) if (sel < 0 && elig[i]) sel = i;
                m_id = sel;
                m_pc = pc_in_i;
                ie_n = 1'b0;
                t_n  = 0;
            end
        end else begin
            t_n = (m_t == LAST) ? -1 : m_t + 1;
        end
        m_pend = (m_pend & ~ack) | (irq_i & ~m_prev);
        m_prev = irq_i;
        m_ie   = ie_n;
        m_t    = t_n;
    endtask

    task automatic compare_outputs();
        logic busy, push, load, jump;
        logic [11:0]    ctrl;
        logic [DW-1:0]  e_data;
        logic [AW-1:0]  e_addr;
        busy   = (m_t >= 0);
        push   = (m_t >= DC && m_t <= DC + W);
        load   = (m_t >= DC + W + 1 && m_t <= DC + 2 * W);
        jump   = (m_t == LAST);
        ctrl   = {busy, busy, jump, load, push, push, push, push, push ? 4'b0100 : 4'b0000};
        e_data = '0;
        e_addr = '0;
        if (m_t >= DC && m_t < DC + W) e_data = DW'(m_pc >> (DW * (W - 1 - (m_t - DC))));
        if (m_t == DC + W) e_data = DW'(m_flags);
        if (load) e_addr = AW'(VB + m_id * W + (m_t - DC - W - 1));
        check("ctrl", {int_flag_o, stall_fetch_o, branch_o, dmr_o, dmw_o, stack_operation_o,
                       push_pop_o, write_sp_o, alu_function_o}, ctrl);
        check("int_data", int_data_o, e_data);
        check("int_addr", int_addr_o, e_addr);
        check("new_pc", new_pc_o, jump ? m_vec : '0);
        check("irq_ack", irq_ack_o, jump ? NI'(1 << m_id) : '0);
        check("ie", ie_o, m_ie);
    endtask

    // One clock: advance the model, check, and return the vector word requested
    task automatic step();
        logic dmr_now;
        int   a;
        dmr_now = (m_t >= DC + W + 1 && m_t <= DC + 2 * W);
        a = dmr_now ? VB + m_id * W + (m_t - DC - W - 1) : 0;
        @(posedge clk);
        model_update();
        #1;
        mem_rdata_i = dmr_now ? vec_mem[a] : DW'($urandom);
        compare_outputs();
    endtask

    task automatic pulse_rti();
        rti_i = 1'b1;
        step();
        rti_i = 1'b0;
    endtask

    task automatic run_until_branch(input string tag, input logic [NI-1:0] exp_ack);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (branch_o === 1'b1) found = 1'b1;
        end
        check({tag, "_reached"}, found, 1'b1);
        if (found) check({tag, "_ack"}, irq_ack_o, exp_ack);
        step();
    endtask

    initial begin
        vec_mem[0] = 16'h0000; vec_mem[1] = 16'h0100;
        vec_mem[2] = 16'h0000; vec_mem[3] = 16'h0200;
        vec_mem[4] = 16'h0001; vec_mem[5] = 16'h0300;
        vec_mem[6] = 16'h0002; vec_mem[7] = 16'h0400;
        m_t = -1; m_pend = '0; m_prev = '0; m_ie = 1'b1; m_id = 0;
        m_pc = '0; m_vec = '0; m_flags = '0;
        rst_i = 1'b1; irq_i = '0; irq_mask_i = '0; rti_i = 1'b0;
        pc_in_i = '0; flags_in_i = '0; mem_rdata_i = '0;

        // Reset state
        step();
        step();
        rst_i = 1'b0;
        check("rst_ie", ie_o, 1'b1);
        check("rst_int_flag", int_flag_o, 1'b0);
        check("rst_dmw", dmw_o, 1'b0);
        check("rst_ack", irq_ack_o, '0);
        step();

        // Line 0: fixed timeline and pushed/fetched values
        pc_in_i = 32'h0001_2345; flags_in_i = 3'b101; irq_i = 4'b0001;
        step();
        check("t1_flag_n1", int_flag_o, 1'b0);
        for (int c = 2; c <= 11; c++) begin
            step();
            case (c)
                2: check("t1_flag_n2", int_flag_o, 1'b1);
                5: check("t1_push0", {dmw_o, int_data_o}, {1'b1, 16'h0001});
                6: check("t1_push1", {dmw_o, int_data_o}, {1'b1, 16'h2345});
                7: check("t1_pushf", {dmw_o, int_data_o}, {1'b1, 16'h0005});
                8: check("t1_rd0", {dmr_o, int_addr_o}, {1'b1, 20'h0});
                9: check("t1_rd1", {dmr_o, int_addr_o}, {1'b1, 20'h1});
                11: check("t1_jump", {branch_o, new_pc_o, irq_ack_o}, {1'b1, 32'h100, 4'b0001});
                default: ;
            endcase
        end

        // Held-high line is not re-taken; a fresh edge is
        pulse_rti();
        for (int c = 0; c < 5; c++) begin
            step();
            check("t1_no_reentry", int_flag_o, 1'b0);
        end
        irq_i = 4'b0000;
        step();
        irq_i = 4'b0001;
        run_until_branch("t1_reedge", 4'b0001);

        // Two lines together: line 1 first, line 2 waits for rti
        irq_i = '0;
        step();
        pulse_rti();
        irq_i = 4'b0110;
        run_until_branch("t2_first", 4'b0010);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t2_wait_rti", int_flag_o, 1'b0);
        end
        pulse_rti();
        run_until_branch("t2_second", 4'b0100);

        // Masked line stays pending until unmasked
        irq_i = '0;
        pulse_rti();
        irq_mask_i = 4'b0001;
        irq_i = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t3_masked", int_flag_o, 1'b0);
        end
        irq_mask_i = '0;
        run_until_branch("t3_unmask", 4'b0001);

        // Reset in the middle of the PC push
        irq_i = '0;
        step();
        pulse_rti();
        irq_i = 4'b1000;
        for (int c = 0; c < 20 && m_t != DC + 1; c++) step();
        check("t4_at_push1", dmw_o, 1'b1);
        rst_i = 1'b1; irq_i = '0;
        step();
        rst_i = 1'b0;
        check("t4_rst_ie", ie_o, 1'b1);
        check("t4_rst_outs", {int_flag_o, stall_fetch_o, dmw_o, int_data_o}, '0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t4_idle_after", {int_flag_o, dmw_o}, 2'b00);
        end

        // rti coincident with entry leaves ie clear; edge during sequence is kept
        irq_i = 4'b0100;
        step();
        rti_i = 1'b1;
        step();
        rti_i = 1'b0;
        check("t5_ie_cleared", ie_o, 1'b0);
        step();
        irq_i = 4'b1100;
        run_until_branch("t5_first", 4'b0100);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t5_wait_rti", int_flag_o, 1'b0);
        end
        pulse_rti();
        run_until_branch("t5_second", 4'b1000);

        // Random traffic against the model
        irq_i = '0;
        pulse_rti();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NI; b++) if ($urandom_range(0, 7) == 0) irq_i[b] = ~irq_i[b];
            if ($urandom_range(0, 49) == 0) irq_mask_i = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
            rti_i      = ($urandom_range(0, 19) == 0);
            rst_i      = ($urandom_range(0, 199) == 0);
            pc_in_i    = $urandom;
            flags_in_i = FW'($urandom);
            step();
        end
        rti_i = 1'b0;
        rst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
